// File: rtl/sprite_fetch_ctrl_pkg.sv
// Shared PPU constants, attribute bit positions and the sprite fetch FSM state type.
package sprite_fetch_ctrl_pkg;

    localparam logic [8:0] VISIBLE_LINES    = 9'd240;
    localparam logic [8:0] PRERENDER_LINE   = 9'd261;
    localparam logic [8:0] FETCH_START      = 9'd256;
    localparam logic [8:0] FETCH_LEN        = 9'd64;
    localparam logic [8:0] RESET_LINE_CYCLE = 9'd340;

    localparam int ATTR_PRIO  = 5;
    localparam int ATTR_HFLIP = 6;
    localparam int ATTR_VFLIP = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ_LO,
        REQ_HI,
        DONE
    } fetch_state_e;

    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_pattern_addr.sv
// Pattern-table address, sprite row and horizontal-flip byte shaping for one sprite.
module sprite_pattern_addr
    import sprite_fetch_ctrl_pkg::*;
(
    input  logic        obj_size_i,
    input  logic        obj_patt_i,
    input  logic [3:0]  y_off_i,
    input  logic [7:0]  tile_i,
    input  logic [7:0]  attr_i,
    input  logic        plane_i,
    input  logic        empty_i,
    input  logic [7:0]  raw_i,
    output logic [13:0] addr_o,
    output logic [7:0]  pattern_o
);

    logic [3:0] row;

    assign row = attr_i[ATTR_VFLIP] ? ~y_off_i : y_off_i;

    // 8x16 sprites take their table from tile bit 0 and use row bit 3 to pick the half.
    assign addr_o = obj_size_i ? {1'b0, tile_i[0], tile_i[7:1], row[3], plane_i, row[2:0]}
                               : {1'b0, obj_patt_i, tile_i, plane_i, row[2:0]};

    // The shifter emits bit 0 first, so an unflipped sprite needs its byte reversed.
    assign pattern_o = empty_i ? 8'h00
                     : (attr_i[ATTR_HFLIP] ? raw_i : bit_reverse(raw_i));

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Per-scanline sprite pattern fetch sequencer: reads temp OAM, fetches two planes
// per slot from VRAM and loads the sprite shifter set during cycles 256-319.
module sprite_fetch_ctrl
    import sprite_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst,
    input  logic        ce,
    input  logic        sprites_enabled,
    input  logic        obj_size,
    input  logic        obj_patt,
    input  logic [8:0]  scanline,
    input  logic [8:0]  cycle,
    input  logic [7:0]  oam_bus,
    output logic        vram_req,
    output logic [13:0] vram_addr,
    input  logic        vram_ack,
    input  logic [7:0]  vram_data,
    output logic [3:0]  spr_load,
    output logic [26:0] spr_load_in,
    output logic        spr_enable,
    output logic        oam_reset_line,
    output logic        fetch_late
);

    fetch_state_e state_q;
    logic         vram_req_q;
    logic [13:0]  vram_addr_q;
    logic [3:0]   y_off_q;
    logic         empty_q;
    logic [7:0]   tile_q;
    logic [7:0]   attr_q;
    logic [7:0]   x_q;
    logic [7:0]   lo_q;
    logic [7:0]   hi_q;
    logic [7:0]   slot_valid_q;
    logic         kill_q;
    logic         fetch_late_q;
    logic         spr_enable_q;
    logic         spr_enable_d;

    logic         line_ok;
    logic         window;
    logic         active;
    logic         load;
    logic [2:0]   slot;
    logic [2:0]   phase;
    logic [13:0]  pat_addr;
    logic [7:0]   pattern;

    assign slot    = cycle[5:3];
    assign phase   = cycle[2:0];
    assign line_ok = (scanline < VISIBLE_LINES) || (scanline == PRERENDER_LINE);
    assign window  = (cycle >= FETCH_START) && (cycle < FETCH_START + FETCH_LEN);
    assign active  = sprites_enabled && line_ok && window;

    assign spr_enable_d = sprites_enabled && (scanline < VISIBLE_LINES)
                       && (cycle >= 9'd1) && (cycle <= FETCH_START);

    sprite_pattern_addr u_pattern_addr (
        .obj_size_i (obj_size),
        .obj_patt_i (obj_patt),
        .y_off_i    (y_off_q),
        .tile_i     (tile_q),
        .attr_i     (attr_q),
        .plane_i    (state_q == REQ_LO),
        .empty_i    (empty_q),
        .raw_i      (vram_data),
        .addr_o     (pat_addr),
        .pattern_o  (pattern)
    );

    // Load strobe is decoded in the phase-7 cycle itself so it lines up with the shifter's ce.
    assign load           = ce && active && (phase == 3'd7) && slot_valid_q[slot];
    assign spr_load       = load ? 4'hF : 4'h0;
    assign spr_load_in    = load ? {lo_q, hi_q, x_q, attr_q[1:0], attr_q[ATTR_PRIO]} : 27'd0;
    assign oam_reset_line = ce && !i_rst && (cycle == RESET_LINE_CYCLE);

    assign vram_req   = vram_req_q;
    assign vram_addr  = vram_addr_q;
    assign spr_enable = spr_enable_q;
    assign fetch_late = fetch_late_q;

    // NOTE: every register here is a flop with async reset, so only <= is used in this block.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            vram_req_q   <= 1'b0;
            vram_addr_q  <= 14'd0;
            y_off_q      <= 4'd0;
            empty_q      <= 1'b0;
            tile_q       <= 8'd0;
            attr_q       <= 8'd0;
            x_q          <= 8'd0;
            lo_q         <= 8'd0;
            hi_q         <= 8'd0;
            slot_valid_q <= 8'd0;
            kill_q       <= 1'b0;
            fetch_late_q <= 1'b0;
            spr_enable_q <= 1'b0;
        end else if (ce) begin
            spr_enable_q <= spr_enable_d;

            if (scanline == PRERENDER_LINE && cycle == 9'd1) begin
                fetch_late_q <= 1'b0;
            end

            // A mid-window disable kills the rest of the line even if re-enabled later.
            if (cycle == RESET_LINE_CYCLE) begin
                kill_q <= 1'b0;
            end else if (!sprites_enabled && line_ok && window) begin
                kill_q <= 1'b1;
            end

            if (!active) begin
                state_q    <= IDLE;
                vram_req_q <= 1'b0;
                if (!sprites_enabled) begin
                    slot_valid_q <= 8'd0;
                end
            end else begin
                unique case (phase)
                    3'd0: begin
                        y_off_q            <= oam_bus[3:0];
                        empty_q            <= |oam_bus[7:4];
                        slot_valid_q[slot] <= !kill_q;
                    end
                    3'd1:    tile_q <= oam_bus;
                    3'd2:    attr_q <= oam_bus;
                    3'd3:    x_q    <= oam_bus;
                    default: ;
                endcase

                if (phase == 3'd7) begin
                    state_q            <= IDLE;
                    vram_req_q         <= 1'b0;
                    slot_valid_q[slot] <= 1'b0;
                    if (slot_valid_q[slot] && state_q != DONE) begin
                        fetch_late_q <= 1'b1;
                    end
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (phase == 3'd4 && slot_valid_q[slot]) begin
                                state_q     <= REQ_LO;
                                vram_req_q  <= 1'b1;
                                vram_addr_q <= pat_addr;
                                // Cleared here so a plane never acked loads as 0x00.
                                lo_q        <= 8'd0;
                                hi_q        <= 8'd0;
                            end
                        end
                        REQ_LO: begin
                            if (vram_ack) begin
                                lo_q        <= pattern;
                                vram_addr_q <= pat_addr;
                                state_q     <= REQ_HI;
                            end
                        end
                        REQ_HI: begin
                            if (vram_ack) begin
                                hi_q       <= pattern;
                                vram_req_q <= 1'b0;
                                state_q    <= DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Directed scanline-level bench for sprite_fetch_ctrl with a VRAM responder and
// scoreboard queues for fetch addresses and shifter load words.
module tb_sprite_fetch_ctrl;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        ce;
    logic        sprites_enabled;
    logic        obj_size;
    logic        obj_patt;
    logic [8:0]  scanline;
    logic [8:0]  cycle;
    logic [7:0]  oam_bus;
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_data;
    logic [3:0]  spr_load;
    logic [26:0] spr_load_in;
    logic        spr_enable;
    logic        oam_reset_line;
    logic        fetch_late;

    always #5 clk = ~clk;

    sprite_fetch_ctrl dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .ce             (ce),
        .sprites_enabled(sprites_enabled),
        .obj_size       (obj_size),
        .obj_patt       (obj_patt),
        .scanline       (scanline),
        .cycle          (cycle),
        .oam_bus        (oam_bus),
        .vram_req       (vram_req),
        .vram_addr      (vram_addr),
        .vram_ack       (vram_ack),
        .vram_data      (vram_data),
        .spr_load       (spr_load),
        .spr_load_in    (spr_load_in),
        .spr_enable     (spr_enable),
        .oam_reset_line (oam_reset_line),
        .fetch_late     (fetch_late)
    );

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
        logic       withhold;
    } slot_t;

    int          checks = 0;
    int          errors = 0;
    int          nloads = 0;
    slot_t       slots[8];
    logic        slot_ok[8];
    logic        exp_en;
    logic        exp_late;
    logic [13:0] addr_q[$];
    logic [26:0] word_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [7:0] vmem(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b10};
    endfunction

    function automatic logic [13:0] paddr(input logic sz, input logic patt, input logic [7:0] y,
                                          input logic [7:0] tile, input logic [7:0] attr,
                                          input logic pl);
        logic [3:0] row;
        row = attr[7] ? ~y[3:0] : y[3:0];
        if (sz) return {1'b0, tile[0], tile[7:1], row[3], pl, row[2:0]};
        return {1'b0, patt, tile, pl, row[2:0]};
    endfunction

    function automatic logic [7:0] plane(input logic [7:0] raw, input logic [7:0] y,
                                         input logic [7:0] attr);
        if (y[7:4] != 4'h0) return 8'h00;
        return attr[6] ? raw : rev8(raw);
    endfunction

    task automatic set_slot(input int i, input logic [7:0] y, input logic [7:0] tile,
                            input logic [7:0] attr, input logic [7:0] x, input logic wh);
        slots[i].y        = y;
        slots[i].tile     = tile;
        slots[i].attr     = attr;
        slots[i].x        = x;
        slots[i].withhold = wh;
    endtask

    task automatic table_a(input logic [7:0] wh_mask);
        set_slot(0, 8'h03, 8'h21, 8'h00, 8'h40, wh_mask[0]);
        set_slot(1, 8'hFF, 8'h10, 8'h40, 8'h80, wh_mask[1]);
        set_slot(2, 8'h05, 8'h7E, 8'h43, 8'h11, wh_mask[2]);
        set_slot(3, 8'h07, 8'h02, 8'h80, 8'h20, wh_mask[3]);
        set_slot(4, 8'h02, 8'hA5, 8'hE1, 8'hF8, wh_mask[4]);
        set_slot(5, 8'h00, 8'h33, 8'h22, 8'h00, wh_mask[5]);
        set_slot(6, 8'h06, 8'hC4, 8'h41, 8'h99, wh_mask[6]);
        set_slot(7, 8'h01, 8'h5A, 8'hA0, 8'h07, wh_mask[7]);
    endtask

    task automatic step(input int c, input logic ce_v, input int rst_at);
        logic [8:0]  cv;
        logic [2:0]  sl;
        logic [2:0]  ph;
        logic        act;
        logic        ld;
        logic        ack_v;
        logic        late_v;
        logic [13:0] a0;
        logic [13:0] a1;
        logic [13:0] exp_a;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [26:0] exp_w;
        slot_t       e;
        cv = 9'(c);
        sl = cv[5:3];
        ph = cv[2:0];
        e  = slots[sl];
        cycle = cv;
        ce    = ce_v;
        act = sprites_enabled && (scanline < 9'd240 || scanline == 9'd261) && (cv[8:6] == 3'b100);
        if (cv[8:6] == 3'b100) begin
            case (ph)
                3'd0:    oam_bus = e.y;
                3'd1:    oam_bus = e.tile;
                3'd2:    oam_bus = e.attr;
                3'd3:    oam_bus = e.x;
                default: oam_bus = 8'hA5;
            endcase
        end else begin
            oam_bus = 8'h5A;
        end

        if (act && ce_v && ph == 3'd0 && slot_ok[sl]) begin
            a0 = paddr(obj_size, obj_patt, e.y, e.tile, e.attr, 1'b0);
            a1 = paddr(obj_size, obj_patt, e.y, e.tile, e.attr, 1'b1);
            lo = e.withhold ? 8'h00 : plane(vmem(a0), e.y, e.attr);
            hi = e.withhold ? 8'h00 : plane(vmem(a1), e.y, e.attr);
            if (!e.withhold) begin
                addr_q.push_back(a0);
                addr_q.push_back(a1);
            end
            word_q.push_back({lo, hi, e.x, e.attr[1:0], e.attr[5]});
        end

        late_v = act && ce_v && ph <= 3'd1 && sl != 3'd0
              && slots[sl - 3'd1].withhold && slot_ok[sl - 3'd1];
        ack_v  = late_v || (act && ce_v && slot_ok[sl] && !e.withhold && vram_req);
        vram_ack  = ack_v;
        vram_data = vmem(vram_addr);
        ld = act && ce_v && ph == 3'd7 && slot_ok[sl];

        @(negedge clk);
        if (late_v) begin
            check("late_ack_req_dropped", 32'(vram_req), 32'(1'b0));
        end else if (ack_v) begin
            check("addr_queue_nonempty", 32'(addr_q.size() != 0), 32'(1'b1));
            if (addr_q.size() != 0) begin
                exp_a = addr_q.pop_front();
                check("vram_addr", 32'(vram_addr), 32'(exp_a));
            end
        end
        check("spr_load", 32'(spr_load), ld ? 32'hF : 32'h0);
        if (spr_load != 4'h0) nloads++;
        if (ld) begin
            check("word_queue_nonempty", 32'(word_q.size() != 0), 32'(1'b1));
            if (word_q.size() != 0) begin
                exp_w = word_q.pop_front();
                check("spr_load_in", 32'(spr_load_in), 32'(exp_w));
            end
        end
        check("oam_reset_line", 32'(oam_reset_line), 32'(ce_v && cv == 9'd340));
        check("spr_enable", 32'(spr_enable), 32'(exp_en));
        check("fetch_late", 32'(fetch_late), 32'(exp_late));
        if (act && ce_v && ph == 3'd6 && slot_ok[sl] && e.withhold) begin
            check("req_held_without_ack", 32'(vram_req), 32'(1'b1));
        end

        if (c == rst_at && ce_v) begin
            i_rst = 1'b1;
            #1;
            check("midrst_vram_req", 32'(vram_req), 32'(1'b0));
            check("midrst_vram_addr", 32'(vram_addr), 32'h0);
            check("midrst_spr_load", 32'(spr_load), 32'h0);
            check("midrst_fetch_late", 32'(fetch_late), 32'(1'b0));
            check("midrst_spr_enable", 32'(spr_enable), 32'(1'b0));
            exp_late = 1'b0;
            exp_en   = 1'b0;
            i_rst = 1'b0;
        end

        if (ce_v) begin
            exp_en = sprites_enabled && scanline < 9'd240 && cv >= 9'd1 && cv <= 9'd256;
            if (scanline == 9'd261 && cv == 9'd1) exp_late = 1'b0;
            if (ld && e.withhold) exp_late = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input logic [8:0] line, input logic sz, input logic patt,
                            input bit stall, input int rst_at, input int off_from,
                            input int off_to);
        scanline = line;
        obj_size = sz;
        obj_patt = patt;
        nloads   = 0;
        for (int s = 0; s < 8; s++) begin
            slot_ok[s] = !(rst_at >= 256 + 8*s && rst_at <= 263 + 8*s)
                      && !(off_from >= 0 && 263 + 8*s >= off_from);
        end
        for (int c = 0; c <= 340; c++) begin
            sprites_enabled = !(c >= off_from && c < off_to);
            if (stall && (c % 7 == 3)) step(c, 1'b0, rst_at);
            step(c, 1'b1, rst_at);
        end
        sprites_enabled = 1'b1;
    endtask

    initial begin
        i_rst           = 1'b1;
        ce              = 1'b0;
        sprites_enabled = 1'b0;
        obj_size        = 1'b0;
        obj_patt        = 1'b0;
        scanline        = 9'd0;
        cycle           = 9'd0;
        oam_bus         = 8'h00;
        vram_ack        = 1'b0;
        vram_data       = 8'h00;
        exp_en          = 1'b0;
        exp_late        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vram_req", 32'(vram_req), 32'(1'b0));
        check("rst_vram_addr", 32'(vram_addr), 32'h0);
        check("rst_spr_load", 32'(spr_load), 32'h0);
        check("rst_spr_load_in", 32'(spr_load_in), 32'h0);
        check("rst_spr_enable", 32'(spr_enable), 32'(1'b0));
        check("rst_oam_reset_line", 32'(oam_reset_line), 32'(1'b0));
        check("rst_fetch_late", 32'(fetch_late), 32'(1'b0));
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        sprites_enabled = 1'b1;

        // 8x8, table 1; slot 1 empty, slot 2 never acked.
        table_a(8'b0000_0100);
        run_line(9'd10, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        check("loads_line_10", 32'(nloads), 32'd8);

        // 8x16 on the pre-render line with ce gaps.
        set_slot(0, 8'h09, 8'h35, 8'h80, 8'h10, 1'b0);
        set_slot(1, 8'h0F, 8'hFF, 8'hC2, 8'h20, 1'b0);
        set_slot(2, 8'h00, 8'h00, 8'h01, 8'h30, 1'b0);
        set_slot(3, 8'h2A, 8'h12, 8'h40, 8'h40, 1'b0);
        set_slot(4, 8'h0C, 8'h81, 8'hA3, 8'h50, 1'b0);
        set_slot(5, 8'h05, 8'h44, 8'h60, 8'h60, 1'b0);
        set_slot(6, 8'h0A, 8'h99, 8'h00, 8'h70, 1'b0);
        set_slot(7, 8'h03, 8'h6B, 8'h80, 8'h80, 1'b0);
        run_line(9'd261, 1'b1, 1'b0, 1'b1, -1, -1, -1);
        check("loads_line_261", 32'(nloads), 32'd8);

        // Reset pulse in slot 3's fetch; slot 1 late so the reset visibly clears fetch_late.
        table_a(8'b0000_0010);
        run_line(9'd20, 1'b0, 1'b0, 1'b0, 285, -1, -1);
        check("loads_line_20", 32'(nloads), 32'd7);

        table_a(8'b0000_0000);
        run_line(9'd21, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        check("loads_line_21", 32'(nloads), 32'd8);

        // Sprites disabled at slot 5 phase 2, re-enabled at slot 6 phase 0.
        run_line(9'd22, 1'b0, 1'b1, 1'b0, -1, 298, 304);
        check("loads_line_22", 32'(nloads), 32'd5);

        check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        check("word_queue_drained", 32'(word_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
